// File: rtl/wt_lut_arbiter.sv
// Round-robin arbiter that lends one combinational weight LUT to N_REQ requesters,
// streaming a full DATA_DEPTH-word burst per grant through a registered valid/ready stage.
module wt_lut_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DATA_DEPTH = 16,
  parameter  int N_REQ      = 2,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ID_WIDTH-1:0]   ID_LAST   = ID_WIDTH'(N_REQ - 1);
  localparam logic [ID_WIDTH:0]     N_EXT     = (ID_WIDTH + 1)'(N_REQ);
  localparam logic [N_REQ-1:0]      GRANT_ONE = N_REQ'(1);

  state_t                  state_q;
  logic [N_REQ-1:0]        grant_q;
  logic [ID_WIDTH-1:0]     owner_q, rr_q, id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q, last_q;

  logic [2*N_REQ-1:0]      req_dbl;
  logic [N_REQ-1:0]        req_rot;
  logic [ID_WIDTH-1:0]     pick_off, pick_id, rr_d;
  logic [ID_WIDTH:0]       pick_sum;
  logic                    pick_vld, fire, xfer, at_last;

  // Rotate req so bit 0 is the rr_q requester; the lowest set bit is then the winner.
  always_comb begin
    req_dbl  = {req, req} >> rr_q;
    req_rot  = req_dbl[N_REQ-1:0];
    pick_vld = |req_rot;
    pick_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = ID_WIDTH'(k);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= N_EXT) pick_sum = pick_sum - N_EXT;
    pick_id = pick_sum[ID_WIDTH-1:0];
  end

  assign fire    = !valid_q || out_ready;
  assign xfer    = valid_q && out_ready;
  assign at_last = (addr_q == ADDR_LAST);
  assign rr_d    = (owner_q == ID_LAST) ? '0 : owner_q + ID_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= GRANT_ONE << pick_id;
            owner_q <= pick_id;
            addr_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (fire) begin
            data_q  <= lut_data;
            valid_q <= 1'b1;
            id_q    <= owner_q;
            last_q  <= at_last;
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            if (at_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Output register holds only the last word here; its acceptance ends the burst.
          if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            grant_q <= '0;
            rr_q    <= rr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = grant_q & {N_REQ{xfer && last_q}};
  assign lut_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_last  = last_q;

endmodule
